// File: rtl/video_timing_pkg.sv
// Mode constants, line/frame total helper and colour-bar palette for video_timing_gen.
package video_timing_pkg;

    localparam int VGA640_H_VISIBLE  = 640;
    localparam int VGA640_H_FRONT    = 16;
    localparam int VGA640_H_SYNC     = 96;
    localparam int VGA640_H_BACK     = 48;
    localparam int VGA640_V_VISIBLE  = 480;
    localparam int VGA640_V_FRONT    = 10;
    localparam int VGA640_V_SYNC     = 2;
    localparam int VGA640_V_BACK     = 33;

    localparam int SVGA800_H_VISIBLE = 800;
    localparam int SVGA800_H_FRONT   = 40;
    localparam int SVGA800_H_SYNC    = 128;
    localparam int SVGA800_H_BACK    = 88;
    localparam int SVGA800_V_VISIBLE = 600;
    localparam int SVGA800_V_FRONT   = 1;
    localparam int SVGA800_V_SYNC    = 4;
    localparam int SVGA800_V_BACK    = 23;

    localparam int NUM_BARS = 8;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    function automatic int vtg_total(input int visible, input int front,
                                     input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = RGB_WHITE;
            3'd1:    rgb = RGB_YELLOW;
            3'd2:    rgb = RGB_CYAN;
            3'd3:    rgb = RGB_GREEN;
            3'd4:    rgb = RGB_MAGENTA;
            3'd5:    rgb = RGB_RED;
            3'd6:    rgb = RGB_BLUE;
            default: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync/first region decode.
module vtg_axis_counter
    import video_timing_pkg::*;
#(
    parameter int CW      = 12,
    parameter int VISIBLE = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          adv_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o,
    output logic          active_o,
    output logic          sync_o,
    output logic          first_o
);

    localparam int          TOTAL   = vtg_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] VIS     = CW'(VISIBLE);
    localparam logic [CW-1:0] SYNC_LO = CW'(VISIBLE + FRONT);
    localparam logic [CW-1:0] SYNC_HI = CW'(VISIBLE + FRONT + SYNC);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign wrap_o   = adv_i && (cnt_q == LAST);
    assign active_o = cnt_q < VIS;
    assign sync_o   = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);
    assign first_o  = cnt_q == '0;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator; all outputs registered, one cycle behind the counters.
// Optional colour-bar test pattern on tp_r/g/b when VTG_TEST_PATTERN_EN is defined.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_VISIBLE = VGA640_H_VISIBLE,
    parameter int H_FRONT   = VGA640_H_FRONT,
    parameter int H_SYNC    = VGA640_H_SYNC,
    parameter int H_BACK    = VGA640_H_BACK,
    parameter int V_VISIBLE = VGA640_V_VISIBLE,
    parameter int V_FRONT   = VGA640_V_FRONT,
    parameter int V_SYNC    = VGA640_V_SYNC,
    parameter int V_BACK    = VGA640_V_BACK,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CW        = 12
) (
    input  logic          clk_pixel,
    input  logic          rst_pixel,
    input  logic          ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          blank,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank,
    output logic          vblank_start,
`ifdef VTG_TEST_PATTERN_EN
    output logic [7:0]    tp_r,
    output logic [7:0]    tp_g,
    output logic [7:0]    tp_b,
`endif
    output logic [15:0]   frame_count
);

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_wrap, h_act, h_sync, h_first;
    logic          v_wrap, v_act, v_sync, v_first;

    vtg_axis_counter #(
        .CW(CW), .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h_axis (
        .clk_i(clk_pixel), .rst_i(rst_pixel), .adv_i(ce),
        .cnt_o(h_cnt), .wrap_o(h_wrap), .active_o(h_act), .sync_o(h_sync), .first_o(h_first)
    );

    vtg_axis_counter #(
        .CW(CW), .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v_axis (
        .clk_i(clk_pixel), .rst_i(rst_pixel), .adv_i(h_wrap),
        .cnt_o(v_cnt), .wrap_o(v_wrap), .active_o(v_act), .sync_o(v_sync), .first_o(v_first)
    );

    logic          hsync_q, vsync_q, de_q, vblank_q;
    logic          line_start_q, frame_start_q, vblank_start_q;
    logic [CW-1:0] x_q, y_q;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          hsync_d, vsync_d, de_d, vblank_d;
    logic          line_start_d, frame_start_d, vblank_start_d;
    logic [CW-1:0] x_d, y_d;
    // Set on the last-pixel edge so the count bumps alongside frame_start, not before it.
    logic          frame_done_q;

    always_comb begin
        hsync_d        = h_sync ? HS_POL : ~HS_POL;
        vsync_d        = v_sync ? VS_POL : ~VS_POL;
        de_d           = h_act && v_act;
        x_d            = de_d ? h_cnt : '0;
        y_d            = de_d ? v_cnt : '0;
        line_start_d   = h_first;
        frame_start_d  = h_first && v_first;
        vblank_d       = !v_act;
        vblank_start_d = h_first && (v_cnt == CW'(V_VISIBLE));
        frame_count_d  = frame_done_q ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge clk_pixel) begin
        if (rst_pixel) begin
            hsync_q        <= ~HS_POL;
            vsync_q        <= ~VS_POL;
            de_q           <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_q       <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= 16'd0;
            frame_done_q   <= 1'b0;
        end else if (ce) begin
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            de_q           <= de_d;
            x_q            <= x_d;
            y_q            <= y_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_q       <= vblank_d;
            vblank_start_q <= vblank_start_d;
            frame_count_q  <= frame_count_d;
            frame_done_q   <= v_wrap;
        end else begin
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign de           = de_q;
    assign blank        = ~de_q;
    assign x            = x_q;
    assign y            = y_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank       = vblank_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;

`ifdef VTG_TEST_PATTERN_EN
    localparam int            BAR_W    = (H_VISIBLE / NUM_BARS > 0) ? H_VISIBLE / NUM_BARS : 1;
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

    // Bar state tracks the live h counter; the last bar absorbs the remainder pixels.
    logic [CW-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [23:0]   tp_q, tp_d;

    always_comb begin
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        tp_d      = de_d ? bar_rgb(bar_idx_q) : 24'd0;
        if (h_wrap) begin
            bar_pix_d = '0;
            bar_idx_d = 3'd0;
        end else if (bar_pix_q == BAR_LAST && bar_idx_q != 3'd7) begin
            bar_pix_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end else begin
            bar_pix_d = bar_pix_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst_pixel) begin
            bar_pix_q <= '0;
            bar_idx_q <= 3'd0;
            tp_q      <= 24'd0;
        end else if (ce) begin
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            tp_q      <= tp_d;
        end
    end

    assign tp_r = tp_q[23:16];
    assign tp_g = tp_q[15:8];
    assign tp_b = tp_q[7:0];
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen in a small 12x7 raster with active-high hsync.
module tb_video_timing_gen;

    localparam int HV = 8, HF = 1, HS = 2, HB = 1;
    localparam int VV = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int CW = 12;

    logic          clk_pixel = 1'b0;
    logic          rst_pixel = 1'b1;
    logic          ce = 1'b1;
    logic          hsync, vsync, de, blank, line_start, frame_start, vblank, vblank_start;
    logic [CW-1:0] x, y;
    logic [15:0]   frame_count;
`ifdef VTG_TEST_PATTERN_EN
    logic [7:0]    tp_r, tp_g, tp_b;
`endif

    video_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HS_POL(1'b1), .VS_POL(1'b0), .CW(CW)
    ) dut (
        .clk_pixel(clk_pixel), .rst_pixel(rst_pixel), .ce(ce),
        .hsync(hsync), .vsync(vsync), .de(de), .blank(blank), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .vblank(vblank),
        .vblank_start(vblank_start),
`ifdef VTG_TEST_PATTERN_EN
        .tp_r(tp_r), .tp_g(tp_g), .tp_b(tp_b),
`endif
        .frame_count(frame_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: counter position (ch,cv) and expected registered outputs.
    int          ch = 0, cv = 0, rh = 0, rv = 0;
    logic        e_hs, e_vs, e_de, e_ls, e_fs, e_vb, e_vbs;
    int          e_x, e_y;
    logic [15:0] e_fc;
    logic        started;
    logic [23:0] e_tp;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int          cyc = 0;
    int          last_fs = -1;
    int          exp_period = HT * VT;
    logic        prev_ls = 1'b0, prev_fs = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_chk++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, req, cyc);
    endtask

    task automatic model_reset();
        ch = 0; cv = 0; rh = 0; rv = 0;
        e_hs = 1'b0; e_vs = 1'b1; e_de = 1'b0; e_x = 0; e_y = 0;
        e_ls = 1'b0; e_fs = 1'b0; e_vb = 1'b0; e_vbs = 1'b0;
        e_fc = 16'd0; started = 1'b0; e_tp = 24'd0;
    endtask

    task automatic tick(input logic ce_v);
        ce = ce_v;
        @(posedge clk_pixel);
        #1;
        cyc++;
        if (rst_pixel) begin
            model_reset();
        end else if (ce_v) begin
            rh = ch; rv = cv;
            e_hs  = (rh >= HV + HF) && (rh < HV + HF + HS);
            e_vs  = !((rv >= VV + VF) && (rv < VV + VF + VS));
            e_de  = (rh < HV) && (rv < VV);
            e_x   = e_de ? rh : 0;
            e_y   = e_de ? rv : 0;
            e_ls  = (rh == 0);
            e_fs  = (rh == 0) && (rv == 0);
            e_vb  = (rv >= VV);
            e_vbs = (rh == 0) && (rv == VV);
            e_tp  = e_de ? bars[rh] : 24'd0;
            if (e_fs && started) e_fc = e_fc + 16'd1;
            started = 1'b1;
            ch = ch + 1;
            if (ch == HT) begin
                ch = 0;
                cv = (cv == VT - 1) ? 0 : cv + 1;
            end
        end else begin
            e_ls = 1'b0; e_fs = 1'b0; e_vbs = 1'b0;
        end
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("blank", 32'(blank), 32'(!e_de));
        chk("x", 32'(x), 32'(e_x));
        chk("y", 32'(y), 32'(e_y));
        chk("line_start", 32'(line_start), 32'(e_ls));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("vblank", 32'(vblank), 32'(e_vb));
        chk("vblank_start", 32'(vblank_start), 32'(e_vbs));
        chk("frame_count", 32'(frame_count), 32'(e_fc));
`ifdef VTG_TEST_PATTERN_EN
        chk("tp_rgb", 32'({tp_r, tp_g, tp_b}), 32'(e_tp));
`endif
        chk("ls_single", 32'(line_start & prev_ls), 32'd0);
        chk("fs_single", 32'(frame_start & prev_fs), 32'd0);
        prev_ls = line_start;
        prev_fs = frame_start;
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(exp_period));
            last_fs = cyc;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_pixel = 1'b1;
        tick(1'b1);
        tick(1'b1);

        // Reset release: first edge registers the origin.
        rst_pixel = 1'b0;
        tick(1'b1);
        chk("first_de", 32'(de), 32'd1);
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("first_ls", 32'(line_start), 32'd1);
        chk("first_fc", 32'(frame_count), 32'd0);

        // Two full frames with ce held high.
        exp_period = HT * VT;
        for (int i = 0; i < 2 * HT * VT; i++) tick(1'b1);
        chk("fc_after_2", 32'(frame_count), 32'd2);

        // ce toggling halves the raster rate.
        exp_period = 2 * HT * VT;
        for (int i = 0; i < 4 * HT * VT; i++) tick(i[0]);
        chk("fc_after_toggle", 32'(frame_count), 32'd4);

        // Mid-frame reset at (3,2), with ce=1 to show reset wins.
        begin
            int guard;
            guard = 0;
            while (!(rh == 3 && rv == 2) && guard < 2 * HT * VT) begin
                tick(1'b1);
                guard++;
            end
            chk("reach_3_2", 32'(guard < 2 * HT * VT), 32'd1);
        end
        rst_pixel = 1'b1;
        last_fs = -1;
        tick(1'b1);
        chk("rst_mid_de", 32'(de), 32'd0);
        chk("rst_mid_fc", 32'(frame_count), 32'd0);
        rst_pixel = 1'b0;
        tick(1'b1);
        chk("rerun_fs", 32'(frame_start), 32'd1);
        exp_period = HT * VT;
        for (int i = 0; i < HT * VT + 4; i++) tick(1'b1);
        chk("fc_after_rerun", 32'(frame_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
